// File: rtl/and_gate_sweeper.sv
// Self-test sequencer for a 2-input AND gate: steps {a,b} through 00..11,
// samples the gate output at the end of each hold window and reports mismatches.
module and_gate_sweeper #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  err_q, err_d;
  logic        pass_q, pass_d;
  logic        gate_a_q, gate_a_d;
  logic        gate_b_q, gate_b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      hold_q   <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      hold_q   <= hold_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they describe (busy with DRIVE, done/pass with DONE).
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 2'd0;
          hold_d  = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          if (gate_c != (vec_q[1] & vec_q[0])) mask_d[vec_q] = 1'b1;
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
            pass_d  = (mask_d == 4'd0);
          end else begin
            vec_d  = vec_q + 2'd1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a sample landing on the same edge.
    if (abort) begin
      state_d = S_IDLE;
      vec_d   = vec_q;
      hold_d  = hold_q;
      mask_d  = mask_q;
      pass_d  = 1'b0;
    end
    gate_a_d = (state_d == S_DRIVE) & vec_d[1];
    gate_b_d = (state_d == S_DRIVE) & vec_d[0];
    busy_d   = (state_d == S_DRIVE);
    done_d   = (state_d == S_DONE);
    err_d    = popcount4(mask_d);
  end

  assign gate_a      = gate_a_q;
  assign gate_b      = gate_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_mask   = mask_q;
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_and_gate_sweeper.sv
// Bench for and_gate_sweeper: two instances (H=20 and H=1) drive a gate modelled
// as a 4-entry truth table; done results are scoreboarded against a reference model.
module tb_and_gate_sweeper;

  localparam int H20 = 20;
  localparam int H1  = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       start20, abort20, a20, b20, c20, busy20, done20, pass20;
  logic [3:0] mask20, tt20;
  logic [2:0] err20;
  logic [1:0] dbg20;
  logic       start1, abort1, a1, b1, c1, busy1, done1, pass1;
  logic [3:0] mask1, tt1;
  logic [2:0] err1;
  logic [1:0] dbg1;

  assign c20 = tt20[{a20, b20}];
  assign c1  = tt1[{a1, b1}];

  and_gate_sweeper #(.HOLD_CYCLES(H20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .abort(abort20),
    .gate_a(a20), .gate_b(b20), .gate_c(c20), .busy(busy20), .done(done20),
    .pass(pass20), .fail_mask(mask20), .err_count(err20), .dbg_state_o(dbg20)
  );

  and_gate_sweeper #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .gate_a(a1), .gate_b(b1), .gate_c(c1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(mask1), .err_count(err1), .dbg_state_o(dbg1)
  );

  // scoreboard entries: {done cycle[15:0], pass, fail_mask[3:0], err_count[2:0]}
  logic [23:0] exp20_q[$];
  logic [23:0] exp1_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: vector k mismatches when the gate's truth table differs from AND at k
  function automatic logic [7:0] model(input logic [3:0] tt);
    logic [3:0] m;
    int         e;
    e = 0;
    for (int k = 0; k < 4; k++) begin
      m[k] = (tt[k] != (k == 3));
      e += int'(m[k]);
    end
    return {(m == 4'd0), m, 3'(e)};
  endfunction

  // {a, b, busy, done, pass, mask[3:0], err[2:0]}
  function automatic logic [11:0] obs(input bit d1);
    return d1 ? {a1, b1, busy1, done1, pass1, mask1, err1}
              : {a20, b20, busy20, done20, pass20, mask20, err20};
  endfunction

  task automatic set_start(input bit d1, input logic v);
    if (d1) start1 = v; else start20 = v;
  endtask
  task automatic set_abort(input bit d1, input logic v);
    if (d1) abort1 = v; else abort20 = v;
  endtask
  task automatic set_tt(input bit d1, input logic [3:0] v);
    if (d1) tt1 = v; else tt20 = v;
  endtask

  // monitors
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && done20) begin
      if (exp20_q.size() == 0) begin
        check("unexpected_done20", 1, 0);
      end else begin
        e = exp20_q.pop_front();
        check("done20_cycle", cyc & 32'hffff, int'(e[23:8]));
        check("done20_pass", int'(pass20), int'(e[7]));
        check("done20_mask", int'(mask20), int'(e[6:3]));
        check("done20_err", int'(err20), int'(e[2:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && done1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_done1", 1, 0);
      end else begin
        e = exp1_q.pop_front();
        check("done1_cycle", cyc & 32'hffff, int'(e[23:8]));
        check("done1_pass", int'(pass1), int'(e[7]));
        check("done1_mask", int'(mask1), int'(e[6:3]));
        check("done1_err", int'(err1), int'(e[2:0]));
      end
    end
  end

  // One sweep from IDLE; returns at the first negedge where a new start may be issued.
  task automatic sweep(input bit d1, input logic [3:0] tt, input bit chk_seq,
                       input int repulse_at, input int abort_at);
    int          h;
    logic [11:0] o;
    logic [7:0]  mres;
    logic [3:0]  low;
    int          nvec;
    h    = d1 ? H1 : H20;
    mres = model(tt);
    @(negedge clk);
    set_tt(d1, tt);
    set_abort(d1, 1'b0);
    set_start(d1, 1'b1);
    if (abort_at < 0) begin
      if (d1) exp1_q.push_back({16'(cyc + 1 + 4 * h), mres});
      else    exp20_q.push_back({16'(cyc + 1 + 4 * h), mres});
    end
    @(negedge clk);
    set_start(d1, 1'b0);
    for (int j = 0; j <= 4 * h; j++) begin
      if (j == abort_at) begin
        set_abort(d1, 1'b1);
        @(negedge clk);
        set_abort(d1, 1'b0);
        o    = obs(d1);
        nvec = j / h;
        low  = 4'((1 << nvec) - 1);
        check("abort_busy", int'(o[9]), 0);
        check("abort_gates", int'(o[11:10]), 0);
        check("abort_done", int'(o[8]), 0);
        check("abort_pass", int'(o[7]), 0);
        check("abort_partial_mask", int'(o[6:3]), int'(mres[6:3] & low));
        return;
      end
      if (chk_seq) begin
        o = obs(d1);
        if (j < 4 * h) begin
          check("seq_vector", int'(o[11:10]), j / h);
          check("seq_busy", int'(o[9]), 1);
        end else begin
          check("end_gates", int'(o[11:10]), 0);
          check("end_busy", int'(o[9]), 0);
          check("end_done", int'(o[8]), 1);
        end
      end
      if (j == repulse_at) set_start(d1, 1'b1);
      if (j == repulse_at + 1) set_start(d1, 1'b0);
      @(negedge clk);
    end
    if (chk_seq) begin
      o = obs(d1);
      check("idle_done_low", int'(o[8]), 0);
      check("idle_pass_held", int'(o[7]), int'(mres[7]));
    end
  endtask

  initial begin
    logic [11:0] o;
    rst_n = 1'b0;
    start20 = 1'b0; abort20 = 1'b0; tt20 = 4'b1000;
    start1  = 1'b0; abort1  = 1'b0; tt1  = 4'b1000;
    repeat (2) @(negedge clk);
    check("reset_outputs20", int'(obs(1'b0)), 0);
    check("reset_outputs1", int'(obs(1'b1)), 0);
    check("reset_state20", int'(dbg20), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // correct AND, OR substitute, stuck-at-1 with H=1
    sweep(1'b0, 4'b1000, 1'b1, -1, -1);
    repeat (3) @(negedge clk);
    check("pass_held_idle", int'(pass20), 1);
    sweep(1'b0, 4'b1110, 1'b0, -1, -1);
    sweep(1'b1, 4'b1111, 1'b1, -1, -1);

    // start re-pulsed during vector 2 is ignored; then abort during vector 2
    sweep(1'b0, 4'b1000, 1'b1, 45, -1);
    sweep(1'b0, 4'b1110, 1'b0, -1, 45);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", int'(busy20), 0);

    // async reset mid-cycle during vector 1, then a clean sweep
    @(negedge clk);
    tt20 = 4'b1111;
    start20 = 1'b1;
    exp20_q.push_back({16'(cyc + 1 + 4 * H20), model(4'b1111)});
    @(negedge clk);
    start20 = 1'b0;
    repeat (25) @(negedge clk);
    check("pre_reset_mask", int'(mask20), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(obs(1'b0)), 0);
    check("async_reset_state", int'(dbg20), 0);
    void'(exp20_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b0, 4'b1000, 1'b0, -1, -1);

    // start and abort together in IDLE
    @(negedge clk);
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    check("start_abort_busy", int'(busy1), 0);
    check("start_abort_gates", int'({a1, b1}), 0);
    repeat (6) @(negedge clk);
    check("start_abort_still_idle", int'(busy1), 0);

    // random truth tables, back-to-back and with gaps
    for (int i = 0; i < 12; i++) begin
      sweep(1'b1, 4'($urandom_range(0, 15)), 1'b0, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      sweep(1'b0, 4'($urandom_range(0, 15)), 1'b0, -1, -1);
    end

    repeat (5) @(negedge clk);
    check("missing_done20", exp20_q.size(), 0);
    check("missing_done1", exp1_q.size(), 0);
    o = obs(1'b0);
    check("final_busy20", int'(o[9]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
